// File: rtl/muldiv_unit_if.sv
// Operand, mthi/mtlo and result bundle between the execute-stage controller
// and the multi-cycle multiply/divide unit.
interface muldiv_unit_if #(
  parameter int N = 32
) ();
  logic         start;
  logic         op;
  logic [N-1:0] rda;
  logic [N-1:0] rdx;
  logic         hi_we;
  logic         lo_we;
  logic [N-1:0] wdata;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         div_by_zero;

  modport master (
    output start, op, rda, rdx, hi_we, lo_we, wdata,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, rda, rdx, hi_we, lo_we, wdata,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 shift-add unsigned multiplier and restoring divider sharing one
// accumulator pair, with architectural HI/LO registers and a busy stall flag.
module muldiv_unit #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input logic           clk,
  input logic           reset_n,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, low_q, opd_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, dbz_q;
  logic [N-1:0]  hi_q, lo_q;

  logic          accept, last;
  logic [N:0]    mul_sum, div_rem, div_diff;
  logic          div_borrow;
  logic [N-1:0]  acc_d, low_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = (cnt_q == CW'(N - 1));
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = bus.op ? DIV : MUL;
        end
      end
      MUL, DIV: begin
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The divider keeps the bit shifted out of R so divisors above 2^(N-1) still work.
  always_comb begin
    mul_sum    = {1'b0, acc_q} + (low_q[0] ? {1'b0, opd_q} : {(N+1){1'b0}});
    div_rem    = {acc_q, low_q[N-1]};
    div_diff   = div_rem - {1'b0, opd_q};
    div_borrow = (div_rem < {1'b0, opd_q});
    acc_d      = acc_q;
    low_d      = low_q;
    case (state_q)
      MUL: begin
        acc_d = mul_sum[N:1];
        low_d = {mul_sum[0], low_q[N-1:1]};
      end
      DIV: begin
        if (div_borrow) begin
          acc_d = div_rem[N-1:0];
          low_d = {low_q[N-2:0], 1'b0};
        end else begin
          acc_d = div_diff[N-1:0];
          low_d = {low_q[N-2:0], 1'b1};
        end
      end
      default: begin
        acc_d = acc_q;
        low_d = low_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      low_q  <= '0;
      opd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        acc_q  <= '0;
        low_q  <= bus.op ? bus.rda : bus.rdx;
        opd_q  <= bus.op ? bus.rdx : bus.rda;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (state_q != IDLE) begin
        acc_q <= acc_d;
        low_q <= low_d;
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          cnt_q  <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          hi_q   <= acc_d;
          lo_q   <= low_d;
          dbz_q  <= (state_q == DIV) && (opd_q == '0);
        end
      end else begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule
